// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, FSM state types and the parity helper
// used by both halves of uart_xcvr.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;
  localparam int MAX_DATA_BITS = 16;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Callers zero-extend narrower payloads; extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running 0..CLKS_PER_BIT-1 bit-cell counter with a
// synchronous clear, an end-of-bit strobe and three mid-bit sample strobes.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end,
  output logic sample_early,
  output logic sample_mid,
  output logic sample_late
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn || clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end      = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign sample_early = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign sample_mid   = (cnt == CNT_W'(CLKS_PER_BIT / 2));
  assign sample_late  = (cnt == CNT_W'(CLKS_PER_BIT / 2 + 1));

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with configurable width, oversampling, parity
// and stop bits; the receiver votes three mid-bit samples per bit.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_busy,
  output logic                 tx_channel_out,
  input  logic                 rx_channel_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_out_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_xcvr: DATA_BITS must be in 5..16");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_xcvr: CLKS_PER_BIT must be at least 4");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("uart_xcvr: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [IDX_W-1:0]     tx_idx;
  logic                 tx_par;
  logic                 tx_stop_cnt;
  logic                 tx_bit_end, tx_s_early, tx_s_mid, tx_s_late;
  logic                 tx_unused_strobes;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (tx_state == TX_IDLE),
    .bit_end      (tx_bit_end),
    .sample_early (tx_s_early),
    .sample_mid   (tx_s_mid),
    .sample_late  (tx_s_late)
  );

  // The transmitter only needs bit boundaries; the sample strobes are RX-only.
  assign tx_unused_strobes = tx_s_early ^ tx_s_mid ^ tx_s_late;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state       <= TX_IDLE;
      tx_busy        <= 1'b0;
      tx_channel_out <= 1'b1;
      tx_shift       <= '0;
      tx_idx         <= '0;
      tx_par         <= 1'b0;
      tx_stop_cnt    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          tx_state       <= TX_START;
          tx_busy        <= 1'b1;
          tx_channel_out <= 1'b0;
          tx_shift       <= tx_data_in;
          tx_par         <= calc_parity(MAX_DATA_BITS'(tx_data_in), PARITY_MODE);
        end
        TX_START: if (tx_bit_end) begin
          tx_state       <= TX_DATA;
          tx_channel_out <= tx_shift[0];
          tx_shift       <= tx_shift >> 1;
          tx_idx         <= '0;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_idx == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY_MODE != PARITY_NONE) begin
              tx_state       <= TX_PARITY;
              tx_channel_out <= tx_par;
            end else begin
              tx_state       <= TX_STOP;
              tx_channel_out <= 1'b1;
              tx_stop_cnt    <= 1'b0;
            end
          end else begin
            tx_idx         <= tx_idx + IDX_W'(1);
            tx_channel_out <= tx_shift[0];
            tx_shift       <= tx_shift >> 1;
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_state       <= TX_STOP;
          tx_channel_out <= 1'b1;
          tx_stop_cnt    <= 1'b0;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_stop_cnt == 1'(STOP_BITS - 1)) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end else begin
            tx_stop_cnt <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t            rx_state;
  logic                 rx_sync1, rx_sync2, rx_prev;
  logic                 rx_fall, rx_vote;
  logic                 rx_s0, rx_s1;
  logic [DATA_BITS-1:0] rx_shift;
  logic [IDX_W-1:0]     rx_idx;
  logic                 rx_par_bad;
  logic                 rx_bit_end, rx_s_early, rx_s_mid, rx_s_late;

  assign rx_fall = rx_prev & ~rx_sync2;
  assign rx_vote = (rx_s0 & rx_s1) | (rx_s0 & rx_sync2) | (rx_s1 & rx_sync2);

  // Not clearing on the detection cycle keeps the counter aligned with the
  // first synchronised low cycle, so the votes straddle the bit centre.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk          (clk),
    .rstn         (rstn),
    .clear        ((rx_state == RX_IDLE) && !rx_fall),
    .bit_end      (rx_bit_end),
    .sample_early (rx_s_early),
    .sample_mid   (rx_s_mid),
    .sample_late  (rx_s_late)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync1      <= 1'b1;
      rx_sync2      <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_busy       <= 1'b0;
      rx_out_valid  <= 1'b0;
      rx_data_out   <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_s0         <= 1'b1;
      rx_s1         <= 1'b1;
      rx_shift      <= '0;
      rx_idx        <= '0;
      rx_par_bad    <= 1'b0;
    end else begin
      rx_sync1     <= rx_channel_in;
      rx_sync2     <= rx_sync1;
      rx_prev      <= rx_sync2;
      rx_out_valid <= 1'b0;
      if (rx_s_early) rx_s0 <= rx_sync2;
      if (rx_s_mid)   rx_s1 <= rx_sync2;
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_state   <= RX_START;
          rx_busy    <= 1'b1;
          rx_par_bad <= 1'b0;
        end
        RX_START: begin
          if (rx_s_late && rx_vote) begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end else if (rx_bit_end) begin
            rx_state <= RX_DATA;
            rx_idx   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_s_late) rx_shift <= {rx_vote, rx_shift[DATA_BITS-1:1]};
          if (rx_bit_end) begin
            if (rx_idx == IDX_W'(DATA_BITS - 1)) begin
              rx_state <= (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end
        end
        RX_PARITY: begin
          if (rx_s_late) rx_par_bad <= (rx_vote != calc_parity(MAX_DATA_BITS'(rx_shift), PARITY_MODE));
          if (rx_bit_end) rx_state <= RX_STOP;
        end
        // Finishing at mid-stop leaves half a bit of slack for the next start edge.
        RX_STOP: if (rx_s_late) begin
          rx_state      <= RX_IDLE;
          rx_busy       <= 1'b0;
          rx_out_valid  <= 1'b1;
          rx_data_out   <= rx_shift;
          rx_parity_err <= rx_par_bad;
          rx_frame_err  <= ~rx_vote;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: TX looped to RX through an XOR noise injector; received frames
// are checked against a scoreboard of expectations derived from the frame rules.
module tb_uart_xcvr;

  localparam int DATA_BITS    = 7;
  localparam int CLKS_PER_BIT = 8;
  localparam int PARITY_MODE  = 1;
  localparam int STOP_BITS    = 1;
  localparam int FRAME_BITS   = 1 + DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
  localparam int F            = CLKS_PER_BIT * FRAME_BITS;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data_in;
  logic                 tx_busy;
  logic                 tx_channel_out;
  logic                 rx_channel_in;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_out_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_busy;
  logic                 flip;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } rx_rec_t;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    int                   flip_lo;
    int                   flip_hi;
    logic [DATA_BITS-1:0] exp_data;
    logic                 exp_perr;
    logic                 exp_ferr;
  } vec_t;

  rx_rec_t exp_q[$];
  int      vectors     = 0;
  int      miscompares = 0;
  logic    prev_valid  = 1'b0;

  uart_xcvr #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_MODE  (PARITY_MODE),
    .STOP_BITS    (STOP_BITS)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .tx_start       (tx_start),
    .tx_data_in     (tx_data_in),
    .tx_busy        (tx_busy),
    .tx_channel_out (tx_channel_out),
    .rx_channel_in  (rx_channel_in),
    .rx_data_out    (rx_data_out),
    .rx_out_valid   (rx_out_valid),
    .rx_parity_err  (rx_parity_err),
    .rx_frame_err   (rx_frame_err),
    .rx_busy        (rx_busy)
  );

  assign rx_channel_in = tx_channel_out ^ flip;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Line level of frame bit bit_no: start, data LSB first, parity, then stop ones.
  function automatic logic model_line_bit(input logic [DATA_BITS-1:0] d, input int bit_no);
    if (bit_no == 0) return 1'b0;
    if (bit_no <= DATA_BITS) return d[bit_no-1];
    if (PARITY_MODE != 0 && bit_no == DATA_BITS + 1) return (PARITY_MODE == 2) ? ~(^d) : ^d;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    rx_rec_t e;
    if (rstn && rx_out_valid) begin
      checkOutput("valid_pulse_width", 32'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(rx_out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rx_data", 32'(rx_data_out), 32'(e.data));
        checkOutput("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
        checkOutput("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
      end
    end
    prev_valid <= rx_out_valid;
  end

  // Sends one frame, flipping the line over [flip_lo, flip_hi] frame cycles and
  // optionally retrying tx_start with 7'h0F at cycle ignore_at.
  task automatic applyStimulus(input logic [DATA_BITS-1:0] data, input int flip_lo,
                               input int flip_hi, input int ignore_at);
    int k;
    int line_err;
    @(negedge clk);
    tx_data_in = data;
    tx_start   = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    k        = 0;
    line_err = 0;
    while (tx_busy && k < 4 * F) begin
      flip = (k >= flip_lo && k <= flip_hi);
      if (tx_channel_out !== model_line_bit(data, k / CLKS_PER_BIT)) line_err++;
      if (k == ignore_at) begin
        tx_data_in = 7'h0F;
        tx_start   = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    flip     = 1'b0;
    tx_start = 1'b0;
    checkOutput("tx_busy_cycles", 32'(k), 32'(F));
    checkOutput("tx_line", 32'(line_err), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("rx_drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t    vecs[5];
    rx_rec_t r;
    logic [DATA_BITS-1:0] d;
    logic    saw_busy;

    vecs[0] = '{7'h55, -1, -1, 7'h55, 1'b0, 1'b0};
    vecs[1] = '{7'h2A, 64, 71, 7'h2A, 1'b1, 1'b0};
    vecs[2] = '{7'h7F, 36, 36, 7'h7F, 1'b0, 1'b0};
    vecs[3] = '{7'h00, 72, 79, 7'h00, 1'b0, 1'b1};
    vecs[4] = '{7'h11, -1, -1, 7'h11, 1'b0, 1'b0};

    rstn       = 1'b0;
    tx_start   = 1'b0;
    tx_data_in = '0;
    flip       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx_channel_out", 32'(tx_channel_out), 1);
    checkOutput("reset_tx_busy", 32'(tx_busy), 0);
    checkOutput("reset_rx_busy", 32'(rx_busy), 0);
    checkOutput("reset_rx_valid", 32'(rx_out_valid), 0);
    checkOutput("reset_rx_data", 32'(rx_data_out), 0);
    checkOutput("reset_rx_errs", 32'({rx_parity_err, rx_frame_err}), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      r = '{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr};
      exp_q.push_back(r);
      applyStimulus(vecs[i].data, vecs[i].flip_lo, vecs[i].flip_hi, -1);
    end
    drain();

    // Back-to-back random frames with one random single-cycle hit inside the
    // data/parity bits; a lone flip can spoil at most one of the three votes.
    for (int i = 0; i < 16; i++) begin
      int hit;
      d   = DATA_BITS'($urandom);
      hit = int'($urandom_range(8, 71));
      r   = '{d, 1'b0, 1'b0};
      exp_q.push_back(r);
      applyStimulus(d, hit, hit, -1);
    end
    drain();

    @(posedge clk);
    #1 flip = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 flip = 1'b0;
    saw_busy = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rx_busy) saw_busy = 1'b1;
    end
    checkOutput("glitch_rx_busy_seen", 32'(saw_busy), 1);
    checkOutput("glitch_rx_busy_clear", 32'(rx_busy), 0);
    repeat (30) @(posedge clk);

    r = '{7'h3C, 1'b0, 1'b0};
    exp_q.push_back(r);
    applyStimulus(7'h3C, -1, -1, 20);
    drain();
    repeat (40) @(posedge clk);

    @(negedge clk);
    tx_data_in = 7'h33;
    tx_start   = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("pre_reset_rx_busy", 32'(rx_busy), 1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_tx_channel_out", 32'(tx_channel_out), 1);
    checkOutput("midreset_tx_busy", 32'(tx_busy), 0);
    checkOutput("midreset_rx_busy", 32'(rx_busy), 0);
    checkOutput("midreset_rx_valid", 32'(rx_out_valid), 0);
    checkOutput("midreset_rx_data", 32'(rx_data_out), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    checkOutput("post_reset_tx_busy", 32'(tx_busy), 0);
    checkOutput("post_reset_rx_busy", 32'(rx_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
